vga_axil_slave: RTL and testbench
=================================

// Module: vga_axil_slave
// PURPOSE
//  AXI4-Lite slave front-end for the VGA text controller. Terminates the five AXI-Lite
//  channels on clk_i and drives the simplified register port consumed by vga_top
//  (axil_waddr/wdata/wstrb/wready, axil_raddr/rreq/rdata). Holds strobes for a fixed
//  window so the clk_i/2 VGA domain always samples them. Produces B and R responses.
// PARAMETERS
//  C_AXI_DATA_WIDTH  32  data bus width (32 only)
//  C_AXI_ADDR_WIDTH  15  byte address width; bit 14 = text buffer region
//  WR_HOLD           2   clk_i cycles axil_wready_o stays high per write (>=2)
//  RD_LATENCY        4   clk_i cycles from rreq_o rise to rdata_i valid (>=3)
// PORTS
//  clk_i            in   1      system clock (2x pixel clock)
//  rst_i            in   1      asynchronous reset, active high
//  s_awvalid_i      in   1      AW valid
//  s_awready_o      out  1      AW ready
//  s_awaddr_i       in   AW     write address
//  s_wvalid_i       in   1      W valid
//  s_wready_o       out  1      W ready
//  s_wdata_i        in   DW     write data
//  s_wstrb_i        in   DW/8   write strobes
//  s_bvalid_o       out  1      B valid
//  s_bready_i       in   1      B ready
//  s_bresp_o        out  2      B response, always OKAY
//  s_arvalid_i      in   1      AR valid
//  s_arready_o      out  1      AR ready
//  s_araddr_i       in   AW     read address
//  s_rvalid_o       out  1      R valid
//  s_rready_i       in   1      R ready
//  s_rdata_o        out  DW     read data
//  s_rresp_o        out  2      R response
//  axil_waddr_o     out  AW     write address to vga_top, registered, stable while wready_o
//  axil_wdata_o     out  DW     write data to vga_top, registered
//  axil_wstrb_o     out  DW/8   write strobes to vga_top, registered
//  axil_wready_o    out  1      write strobe, high WR_HOLD cycles
//  axil_raddr_o     out  AW     read address to vga_top, stable while rreq_o
//  axil_rreq_o      out  1      read request, high RD_LATENCY cycles
//  axil_rdata_i     in   DW     read data from vga_top buffer
// BEHAVIOUR
//  Reset (async, rst_i=1): all valid/ready/strobe outputs 0, addr/data/resp outputs 0,
//   both FSMs to IDLE, counters 0; pending transactions dropped, no response issued.
//  Write FSM W_IDLE -> W_ISSUE -> W_RESP -> W_IDLE:
//   W_IDLE: awready_o=1 until AW captured, wready_o=1 until W captured; AW and W
//    accepted independently in any order or same cycle; each held in a register.
//   Both held -> W_ISSUE next cycle: axil_wready_o=1 for exactly WR_HOLD cycles with
//    waddr/wdata/wstrb constant (downstream writes are idempotent; repeat harmless).
//   W_RESP: bvalid_o=1, bresp_o=2'b00 until bready_i; bready already high ->
//    one-cycle bvalid. Back to W_IDLE, ready re-asserted next cycle.
//   Write latency W+AW handshake -> bvalid: WR_HOLD+1 cycles min.
//  Read FSM R_IDLE -> R_WAIT -> R_RESP -> R_IDLE:
//   R_IDLE: arready_o=1. araddr[14]=1 -> R_WAIT; araddr[14]=0 (font/colour regs,
//    write-only) -> R_RESP directly with rdata_o=0, rresp_o=2'b10 (SLVERR), no rreq.
//   R_WAIT: rreq_o=1, raddr_o held, down-counter RD_LATENCY..1; at 1 capture
//    axil_rdata_i into s_rdata_o, rresp_o=OKAY, go R_RESP.
//   R_RESP: rvalid_o=1, rdata/rresp stable until rready_i.
//  Read and write FSMs independent; simultaneous AR and AW/W both accepted same cycle.
//  Backpressure: one outstanding write and one outstanding read max.
//  Address bits [1:0] passed through unmodified; no alignment check. awprot/arprot absent.
//  Counters sized $clog2(max(WR_HOLD,RD_LATENCY)+1); no wrap, reloaded on each entry.
// STRUCTURE
//  Package vga_axil_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, write/read state
//   encodings, BUF_REGION_BIT=14.
//  Single flat module; no sub-module (two small FSMs + two counters).
// TESTING
//  AW 0x4004 + W 0x41424344 strb 0xF same cycle -> wready_o high 2 cycles, addr/data
//   stable, bvalid next, bresp 00.
//  W first, AW 3 cycles later -> wready_o only after AW, then single B response.
//  AR 0x4010, rdata_i=0x00614263 -> rreq_o high 4 cycles, rvalid with 0x00614263, OKAY.
//  AR 0x0020 -> no rreq_o, rvalid next cycle, rdata 0, rresp 10.
//  bready_i/rready_i low 5 cycles -> bvalid/rvalid and data held, aw/w/arready stay 0.
//  rst_i asserted in R_WAIT and W_ISSUE -> all outputs 0 same cycle, no B/R after release.

Source files
------------

// File: rtl/vga_axil_pkg.sv
// Shared response codes, FSM encodings and address map constants for the
// AXI4-Lite front-end of the VGA text controller.
package vga_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte address bit that selects the readable text buffer; everything
    // below it is the write-only font/colour register space.
    localparam int BUF_REGION_BIT = 14;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_ISSUE = 2'd1,
        W_RESP  = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } r_state_t;

endpackage

// File: rtl/vga_axil_slave.sv
// AXI4-Lite slave that turns AXI write/read transactions into the simple
// strobe-based register port of vga_top. Strobes are stretched over several
// clk_i cycles so the half-rate VGA domain always sees them.
module vga_axil_slave #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 15,
    parameter int WR_HOLD          = 2,
    parameter int RD_LATENCY       = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          s_awvalid_i,
    output logic                          s_awready_o,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   s_awaddr_i,
    input  logic                          s_wvalid_i,
    output logic                          s_wready_o,
    input  logic [C_AXI_DATA_WIDTH-1:0]   s_wdata_i,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] s_wstrb_i,
    output logic                          s_bvalid_o,
    input  logic                          s_bready_i,
    output logic [1:0]                    s_bresp_o,
    input  logic                          s_arvalid_i,
    output logic                          s_arready_o,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   s_araddr_i,
    output logic                          s_rvalid_o,
    input  logic                          s_rready_i,
    output logic [C_AXI_DATA_WIDTH-1:0]   s_rdata_o,
    output logic [1:0]                    s_rresp_o,
    output logic [C_AXI_ADDR_WIDTH-1:0]   axil_waddr_o,
    output logic [C_AXI_DATA_WIDTH-1:0]   axil_wdata_o,
    output logic [C_AXI_DATA_WIDTH/8-1:0] axil_wstrb_o,
    output logic                          axil_wready_o,
    output logic [C_AXI_ADDR_WIDTH-1:0]   axil_raddr_o,
    output logic                          axil_rreq_o,
    input  logic [C_AXI_DATA_WIDTH-1:0]   axil_rdata_i
);
    import vga_axil_pkg::*;

    localparam int CNT_MAX = (WR_HOLD > RD_LATENCY) ? WR_HOLD : RD_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_HOLD);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY);

    w_state_t         w_state;
    r_state_t         r_state;
    logic             aw_held;
    logic             w_held;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic             aw_hs;
    logic             w_hs;

    assign aw_hs = s_awvalid_i && s_awready_o;
    assign w_hs  = s_wvalid_i && s_wready_o;

    // Write FSM: collect AW and W in any order, pulse the downstream strobe
    // for WR_HOLD cycles, then return a single OKAY response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state       <= W_IDLE;
            w_cnt         <= '0;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            s_awready_o   <= 1'b0;
            s_wready_o    <= 1'b0;
            s_bvalid_o    <= 1'b0;
            s_bresp_o     <= RESP_OKAY;
            axil_waddr_o  <= '0;
            axil_wdata_o  <= '0;
            axil_wstrb_o  <= '0;
            axil_wready_o <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    // The capture registers double as the downstream port,
                    // so they stay put for the whole strobe window.
                    if (aw_hs) begin
                        axil_waddr_o <= s_awaddr_i;
                        aw_held      <= 1'b1;
                    end
                    if (w_hs) begin
                        axil_wdata_o <= s_wdata_i;
                        axil_wstrb_o <= s_wstrb_i;
                        w_held       <= 1'b1;
                    end
                    s_awready_o <= !(aw_held || aw_hs);
                    s_wready_o  <= !(w_held || w_hs);
                    if (aw_held && w_held) begin
                        axil_wready_o <= 1'b1;
                        w_cnt         <= WR_LOAD;
                        w_state       <= W_ISSUE;
                    end
                end
                W_ISSUE: begin
                    if (w_cnt == CNT_ONE) begin
                        axil_wready_o <= 1'b0;
                        s_bvalid_o    <= 1'b1;
                        s_bresp_o     <= RESP_OKAY;
                        w_state       <= W_RESP;
                    end else begin
                        w_cnt <= w_cnt - CNT_ONE;
                    end
                end
                W_RESP: begin
                    if (s_bready_i) begin
                        s_bvalid_o  <= 1'b0;
                        aw_held     <= 1'b0;
                        w_held      <= 1'b0;
                        s_awready_o <= 1'b1;
                        s_wready_o  <= 1'b1;
                        w_state     <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM: buffer reads hold rreq for RD_LATENCY cycles and sample the
    // returned word on the last one; register-space reads fail immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= R_IDLE;
            r_cnt        <= '0;
            s_arready_o  <= 1'b0;
            s_rvalid_o   <= 1'b0;
            s_rdata_o    <= '0;
            s_rresp_o    <= RESP_OKAY;
            axil_raddr_o <= '0;
            axil_rreq_o  <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    s_arready_o <= 1'b1;
                    if (s_arvalid_i && s_arready_o) begin
                        s_arready_o <= 1'b0;
                        if (s_araddr_i[BUF_REGION_BIT]) begin
                            axil_raddr_o <= s_araddr_i;
                            axil_rreq_o  <= 1'b1;
                            r_cnt        <= RD_LOAD;
                            r_state      <= R_WAIT;
                        end else begin
                            s_rdata_o  <= '0;
                            s_rresp_o  <= RESP_SLVERR;
                            s_rvalid_o <= 1'b1;
                            r_state    <= R_RESP;
                        end
                    end
                end
                R_WAIT: begin
                    if (r_cnt == CNT_ONE) begin
                        axil_rreq_o <= 1'b0;
                        s_rdata_o   <= axil_rdata_i;
                        s_rresp_o   <= RESP_OKAY;
                        s_rvalid_o  <= 1'b1;
                        r_state     <= R_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                R_RESP: begin
                    if (s_rready_i) begin
                        s_rvalid_o  <= 1'b0;
                        s_arready_o <= 1'b1;
                        r_state     <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_axil_slave.sv
// Bench for vga_axil_slave: directed vector table, reset-in-flight sequences
// and randomized write/read traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_vga_axil_slave;

    localparam int DW         = 32;
    localparam int AW         = 15;
    localparam int WR_HOLD    = 2;
    localparam int RD_LATENCY = 4;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            s_awvalid = 1'b0, s_awready;
    logic [AW-1:0]   s_awaddr = '0;
    logic            s_wvalid = 1'b0, s_wready;
    logic [DW-1:0]   s_wdata = '0;
    logic [DW/8-1:0] s_wstrb = '0;
    logic            s_bvalid, s_bready = 1'b0;
    logic [1:0]      s_bresp;
    logic            s_arvalid = 1'b0, s_arready;
    logic [AW-1:0]   s_araddr = '0;
    logic            s_rvalid, s_rready = 1'b0;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic [AW-1:0]   axil_waddr, axil_raddr;
    logic [DW-1:0]   axil_wdata;
    logic [DW/8-1:0] axil_wstrb;
    logic            axil_wready, axil_rreq;
    logic [DW-1:0]   axil_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_axil_slave #(
        .C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW),
        .WR_HOLD(WR_HOLD), .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .s_awvalid_i(s_awvalid), .s_awready_o(s_awready), .s_awaddr_i(s_awaddr),
        .s_wvalid_i(s_wvalid), .s_wready_o(s_wready), .s_wdata_i(s_wdata), .s_wstrb_i(s_wstrb),
        .s_bvalid_o(s_bvalid), .s_bready_i(s_bready), .s_bresp_o(s_bresp),
        .s_arvalid_i(s_arvalid), .s_arready_o(s_arready), .s_araddr_i(s_araddr),
        .s_rvalid_o(s_rvalid), .s_rready_i(s_rready), .s_rdata_o(s_rdata), .s_rresp_o(s_rresp),
        .axil_waddr_o(axil_waddr), .axil_wdata_o(axil_wdata), .axil_wstrb_o(axil_wstrb),
        .axil_wready_o(axil_wready), .axil_raddr_o(axil_raddr), .axil_rreq_o(axil_rreq),
        .axil_rdata_i(axil_rdata)
    );

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        int          pulse;
    } rd_exp_t;

    typedef struct {
        bit          is_rd;
        logic [14:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        int          resp_dly;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_pulse;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic outs_any();
        return |{s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata,
                 s_rresp, axil_waddr, axil_wdata, axil_wstrb, axil_wready, axil_raddr, axil_rreq};
    endfunction

    // Reference: the text buffer answers with its word after one full request
    // window; the register space is write-only and answers SLVERR with zero.
    function automatic rd_exp_t ref_read(input logic [14:0] addr, input logic [31:0] buf_val);
        rd_exp_t e;
        if (addr[14]) begin
            e.resp = OKAY; e.data = buf_val; e.pulse = RD_LATENCY;
        end else begin
            e.resp = SLVERR; e.data = '0; e.pulse = 0;
        end
        return e;
    endfunction

    task automatic do_write(input string tag, input logic [14:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly, input int exp_pulse);
        int cyc = 0, hs_cyc = -1, b_cyc = -1, pulse = 0, early = 0, hold_bad = 0, stall_bad = 0;
        bit aw_done = 0, w_done = 0, b_done = 0;
        logic [1:0] bresp_seen = 2'b11;
        while (!b_done && cyc < 80) begin
            if (axil_wready) begin
                pulse++;
                if (hs_cyc < 0 || cyc < hs_cyc) early++;
                if (axil_waddr !== addr || axil_wdata !== data || axil_wstrb !== strb) hold_bad++;
            end
            if (s_bvalid && b_cyc < 0) begin
                b_cyc = cyc;
                bresp_seen = s_bresp;
            end
            if (b_cyc >= 0 && (!s_bvalid || s_bresp !== bresp_seen || s_awready || s_wready))
                stall_bad++;
            s_awvalid = !aw_done && cyc >= aw_dly;
            s_awaddr  = s_awvalid ? addr : 15'($urandom);
            s_wvalid  = !w_done && cyc >= w_dly;
            s_wdata   = s_wvalid ? data : $urandom;
            s_wstrb   = s_wvalid ? strb : 4'($urandom);
            s_bready  = b_cyc >= 0 && (cyc - b_cyc) >= b_dly;
            if (s_awvalid && s_awready) aw_done = 1;
            if (s_wvalid && s_wready) w_done = 1;
            if (aw_done && w_done && hs_cyc < 0) hs_cyc = cyc + 1;
            if (s_bready && s_bvalid) b_done = 1;
            tick();
            cyc++;
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        check({tag, "_bdone"}, 64'(b_done), 64'(1));
        check({tag, "_pulse"}, 64'(pulse), 64'(exp_pulse));
        check({tag, "_early"}, 64'(early), 64'(0));
        check({tag, "_hold"}, 64'(hold_bad), 64'(0));
        check({tag, "_blat"}, 64'(b_cyc - hs_cyc), 64'(exp_pulse + 1));
        check({tag, "_bresp"}, 64'(bresp_seen), 64'(OKAY));
        check({tag, "_bstall"}, 64'(stall_bad), 64'(0));
        check({tag, "_rearm"}, 64'({s_bvalid, s_awready, s_wready}), 64'(3'b011));
    endtask

    task automatic do_read(input string tag, input logic [14:0] addr, input logic [31:0] buf_val,
                           input int r_dly, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                           input int exp_pulse);
        int cyc = 0, hs_cyc = -1, r_cyc = -1, pulse = 0, addr_bad = 0, stall_bad = 0;
        bit ar_done = 0, r_done = 0;
        logic [31:0] data_seen = '1;
        logic [1:0]  resp_seen = '1;
        while (!r_done && cyc < 80) begin
            if (axil_rreq) begin
                pulse++;
                if (axil_raddr !== addr) addr_bad++;
            end
            if (s_rvalid && r_cyc < 0) begin
                r_cyc = cyc;
                data_seen = s_rdata;
                resp_seen = s_rresp;
            end
            if (r_cyc >= 0 && (!s_rvalid || s_rdata !== data_seen || s_rresp !== resp_seen ||
                               s_arready || axil_rreq))
                stall_bad++;
            // Buffer word is only valid on the last cycle of the request window.
            axil_rdata = (axil_rreq && pulse == RD_LATENCY) ? buf_val : $urandom;
            s_arvalid  = !ar_done;
            s_araddr   = s_arvalid ? addr : 15'($urandom);
            s_rready   = r_cyc >= 0 && (cyc - r_cyc) >= r_dly;
            if (s_arvalid && s_arready) begin
                ar_done = 1;
                hs_cyc  = cyc + 1;
            end
            if (s_rready && s_rvalid) r_done = 1;
            tick();
            cyc++;
        end
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        check({tag, "_rdone"}, 64'(r_done), 64'(1));
        check({tag, "_rreq"}, 64'(pulse), 64'(exp_pulse));
        check({tag, "_raddr"}, 64'(addr_bad), 64'(0));
        check({tag, "_rlat"}, 64'(r_cyc - hs_cyc), 64'(exp_pulse));
        check({tag, "_rdata"}, 64'(data_seen), 64'(exp_data));
        check({tag, "_rresp"}, 64'(resp_seen), 64'(exp_resp));
        check({tag, "_rstall"}, 64'(stall_bad), 64'(0));
        check({tag, "_rearm"}, 64'({s_rvalid, s_arready}), 64'(2'b01));
    endtask

    // Release reset and confirm nothing resurfaces from the dropped transaction.
    task automatic release_and_idle(input string tag);
        int seen = 0;
        tick();
        tick();
        rst = 1'b0;
        s_bready = 1'b1;
        s_rready = 1'b1;
        repeat (10) begin
            tick();
            if (s_rvalid || s_bvalid || axil_rreq || axil_wready) seen++;
        end
        s_bready = 1'b0;
        s_rready = 1'b0;
        check({tag, "_noresp"}, 64'(seen), 64'(0));
        check({tag, "_ready"}, 64'({s_awready, s_wready, s_arready}), 64'(3'b111));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int kind, awd, wdl, bd, rd;
        logic [14:0] wa, ra;
        logic [31:0] wd, bv;
        logic [3:0]  ws;
        rd_exp_t     e;

        vecs[0] = '{0, 15'h4004, 32'h41424344, 4'hF, 0, 0, 0, 32'h0, OKAY, WR_HOLD};
        vecs[1] = '{0, 15'h4008, 32'hDEADBEEF, 4'h5, 3, 0, 0, 32'h0, OKAY, WR_HOLD};
        vecs[2] = '{0, 15'h0013, 32'h12345678, 4'h8, 0, 2, 5, 32'h0, OKAY, WR_HOLD};
        vecs[3] = '{1, 15'h4010, 32'h00614263, 4'h0, 0, 0, 0, 32'h00614263, OKAY, RD_LATENCY};
        vecs[4] = '{1, 15'h0020, 32'hA5A5A5A5, 4'h0, 0, 0, 0, 32'h0, SLVERR, 0};
        vecs[5] = '{1, 15'h7FFF, 32'hCAFEF00D, 4'h0, 0, 0, 5, 32'hCAFEF00D, OKAY, RD_LATENCY};
        vecs[6] = '{1, 15'h3FFF, 32'h11111111, 4'h0, 0, 0, 2, 32'h0, SLVERR, 0};
        vecs[7] = '{0, 15'h7FFE, 32'h00000000, 4'h0, 1, 1, 1, 32'h0, OKAY, WR_HOLD};

        #2;
        check("reset_outputs", 64'(outs_any()), 64'(0));
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("reset_ready", 64'({s_awready, s_wready, s_arready}), 64'(3'b111));

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_rd)
                do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].resp_dly,
                        vecs[i].exp_rdata, vecs[i].exp_resp, vecs[i].exp_pulse);
            else
                do_write($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].strb,
                         vecs[i].aw_dly, vecs[i].w_dly, vecs[i].resp_dly, vecs[i].exp_pulse);
        end

        // AR together with AW/W in the same cycle: both channels proceed.
        fork
            do_write("both_wr", 15'h4100, 32'h0BADF00D, 4'hF, 0, 0, 0, WR_HOLD);
            do_read("both_rd", 15'h4200, 32'h5EED1234, 0, 32'h5EED1234, OKAY, RD_LATENCY);
        join

        // Reset while the read is waiting for buffer data.
        s_araddr  = 15'h4010;
        s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        tick();
        tick();
        check("rst_rwait_pre", 64'(axil_rreq), 64'(1));
        rst = 1'b1;
        #1;
        check("rst_rwait_zero", 64'(outs_any()), 64'(0));
        release_and_idle("rst_rwait");

        // Reset while the write strobe is being held.
        s_awaddr  = 15'h4004;
        s_wdata   = 32'h41424344;
        s_wstrb   = 4'hF;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        tick();
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        tick();
        check("rst_wissue_pre", 64'(axil_wready), 64'(1));
        rst = 1'b1;
        #1;
        check("rst_wissue_zero", 64'(outs_any()), 64'(0));
        release_and_idle("rst_wissue");

        // Randomized traffic: writes, reads, or both at once.
        for (int i = 0; i < 24; i++) begin
            kind = $urandom_range(2, 0);
            wa   = 15'($urandom);
            ra   = 15'($urandom);
            wd   = $urandom;
            bv   = $urandom;
            ws   = 4'($urandom);
            awd  = $urandom_range(3, 0);
            wdl  = $urandom_range(3, 0);
            bd   = $urandom_range(3, 0);
            rd   = $urandom_range(3, 0);
            e    = ref_read(ra, bv);
            case (kind)
                0: do_write($sformatf("rnd%0d_wr", i), wa, wd, ws, awd, wdl, bd, WR_HOLD);
                1: do_read($sformatf("rnd%0d_rd", i), ra, bv, rd, e.data, e.resp, e.pulse);
                default: begin
                    fork
                        do_write($sformatf("rnd%0d_wr", i), wa, wd, ws, awd, wdl, bd, WR_HOLD);
                        do_read($sformatf("rnd%0d_rd", i), ra, bv, rd, e.data, e.resp, e.pulse);
                    join
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
